menu_cmd_rx: RTL
================

# menu_cmd_rx

Receive side of the serial menu console. It deserializes 8N1 UART bytes from the host terminal and parses one-line menu commands: a single digit `1`..`5` terminated by CR. It delivers the choice as a held valid/ready selection to the application. It also asks the menu printer to re-send the menu on an empty or invalid line. It sits between the `rx` pad and the menu-driven control logic, alongside the menu text ROM and printer on the transmit side.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Legal range is 8..1023.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`
- `sel_ready`  in  1  consumer accepts the selection
- `sel`  out  3  selected item, 1..5
- `sel_valid`  out  1  selection pending; held until accepted
- `menu_req`  out  1  one-cycle pulse: re-print the menu
- `cmd_err`  out  1  one-cycle pulse: invalid command line
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `ovf`  out  1  one-cycle pulse: selection dropped because one was already pending

## Operation
- All outputs reset to 0.
- **Synchronizer.** `rx` passes through 2 flops; all logic uses the synchronized value `rxs`.
- **Receiver FSM.**
  - States: `R_WAIT`, `R_IDLE`, `R_START`, `R_DATA`, `R_STOP`.
  - `R_WAIT`: entered from reset. Moves to `R_IDLE` on the first cycle with `rxs`=1, so a reset released mid-frame never produces a false start.
  - `R_IDLE`: `rxs`=0 moves to `R_START` and loads the counter with CLKS_PER_BIT/2−1.
  - `R_START`: at count 0, `rxs`=0 moves to `R_DATA`; `rxs`=1 is a glitch and returns to `R_IDLE`.
  - `R_DATA`: 8 bits are sampled every CLKS_PER_BIT cycles, LSB first.
  - `R_STOP`: sampled one bit-time after data bit 7. If the stop bit is 1, `byte_valid` pulses for 1 cycle with `byte_data`. If it is 0, `frame_err` pulses, the byte is discarded, and the FSM goes to `R_WAIT`.
- **Parser FSM.** States: `P_IDLE`, `P_DIGIT`, `P_BAD`. LF (0x0A) is ignored in every state.
  - `P_IDLE`:
    - 0x31..0x35 → store digit−0x30, go to `P_DIGIT`.
    - CR (0x0D) → `menu_req`.
    - Any other byte → `P_BAD`.
  - `P_DIGIT`:
    - CR → issue the selection, go to `P_IDLE`.
    - BS (0x08) or DEL (0x7F) → `P_IDLE`, digit cleared.
    - Any other byte, including a second digit → `P_BAD`.
  - `P_BAD`:
    - CR → `cmd_err` and `menu_req` in the same cycle, go to `P_IDLE`.
    - Any other byte → stay.
- **Selection handshake.**
  - Issuing a selection with `sel_valid`=0 loads `sel` and sets `sel_valid`.
  - `sel` and `sel_valid` stay stable until a cycle with `sel_valid`&&`sel_ready`, which clears `sel_valid`. `sel` keeps its last value.
  - Issuing a selection while `sel_valid`=1, including the acceptance cycle itself, pulses `ovf`; the new selection is dropped and the old one is held.
  - The parser never stalls the receiver.
- **Reset.** Asserting `rst_n` at any point aborts the receiver and parser immediately, clears any pending selection, and returns to `R_WAIT`/`P_IDLE`.

## Timing
- The start edge is detected 2–3 cycles after the `rx` fall (synchronizer).
- Samples are taken at mid-bit: start + CLKS_PER_BIT/2 + k·CLKS_PER_BIT, for k = 1..9.
- `byte_valid` occurs in the cycle after the stop-bit sample.
- `sel_valid`, `menu_req`, `cmd_err` and `ovf` are registered and appear 1 cycle after `byte_valid` of the CR.
- `frame_err` is registered in the cycle after the stop-bit sample.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. The receiver returns to `R_IDLE` at the stop mid-sample, leaving half a bit of margin.
- Sustained throughput is one byte per 10·CLKS_PER_BIT cycles.

## Structure
- Shared package `menu_pkg` holds:
  - ASCII constants `ASC_CR`, `ASC_LF`, `ASC_BS`, `ASC_DEL`, `ASC_1`, `ASC_5`.
  - The `MENU_ITEMS`=5 constant.
  - Receiver and parser state typedefs.
- Sub-module `uart_rx_core` covers the synchronizer and receiver FSM. Its outputs are `byte_data`, `byte_valid` and `frame_err`, and the transmit side reuses its bit-timing parameter.
- The parser and handshake live in `menu_cmd_rx`.

## Test plan
All cases use CLKS_PER_BIT=8 unless noted.
- Send "3\r\n" with `sel_ready`=0 → `sel`=3 and `sel_valid`=1, stable for 100 cycles. Raising `sel_ready` clears `sel_valid` next cycle; no `menu_req` or `cmd_err`.
- Send "\r" → one `menu_req` pulse, no `sel_valid`. Send "7\r" or "12\r" → `cmd_err` and `menu_req` pulse together once; `sel_valid` stays 0.
- Send "2", 0x08, "4\r" → `sel`=4. Send "2", 0x7F, "\r" → `menu_req` only.
- Send "1\r" with `sel_ready`=0, then "5\r" → `ovf` pulses once, `sel` stays 1. After acceptance, "5\r" → `sel`=5.
- Send 0x31 with the stop bit driven 0 → `frame_err` pulses and no byte is seen. A following "2\r" after idle → `sel`=2.
- Assert `rst_n`=0 mid-data-bit of "4", release while `rx`=0 → no byte is decoded until `rx` returns high. The next "4\r" → `sel`=4.
- Repeat the first scenario at CLKS_PER_BIT=87 with ±3% baud skew → correct decode.

Source files
------------

// File: rtl/menu_pkg.sv
// menu_pkg: ASCII codes, menu size and FSM state types shared by the menu console receive path.
package menu_pkg;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_DEL = 8'h7F;
  localparam logic [7:0] ASC_1   = 8'h31;
  localparam logic [7:0] ASC_5   = 8'h35;
  localparam int MENU_ITEMS = 5;
  localparam int SEL_W = $clog2(MENU_ITEMS + 1);
  typedef enum logic [2:0] {R_WAIT, R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DIGIT, P_BAD} ps_state_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= ASC_1 && b <= ASC_5;
  endfunction
endpackage

// File: rtl/menu_cmd_rx_if.sv
// menu_cmd_rx_if: selection handshake plus status pulses from the menu receiver to the application.
interface menu_cmd_rx_if;
  import menu_pkg::*;
  logic [SEL_W-1:0] sel;
  logic sel_valid;
  logic sel_ready;
  logic menu_req;
  logic cmd_err;
  logic frame_err;
  logic ovf;
  modport master (input sel_ready, output sel, sel_valid, menu_req, cmd_err, frame_err, ovf);
  modport slave (output sel_ready, input sel, sel_valid, menu_req, cmd_err, frame_err, ovf);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronizer and 8N1 receiver FSM sampling at mid-bit.
module uart_rx_core
  import menu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam logic [9:0] HALF = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] FULL = 10'(CLKS_PER_BIT - 1);
  // Synchronizer resets low so a reset released mid-frame stays in R_WAIT until rx is truly idle.
  logic [1:0] sync;
  logic       rxs;
  rx_state_t  st;
  logic [9:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign rxs = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync       <= '0;
      st         <= R_WAIT;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt == 10'd0 ? FULL : cnt - 10'd1;
      case (st)
        R_WAIT:  if (rxs) st <= R_IDLE;
        R_IDLE:  if (!rxs) begin
          st  <= R_START;
          cnt <= HALF;
        end
        R_START: if (cnt == 10'd0) st <= rxs ? R_IDLE : R_DATA;
        R_DATA:  if (cnt == 10'd0) begin
          sh  <= {rxs, sh[7:1]};
          idx <= idx + 3'd1;
          if (idx == 3'd7) st <= R_STOP;
        end
        R_STOP:  if (cnt == 10'd0) begin
          if (rxs) begin
            byte_valid <= 1'b1;
            byte_data  <= sh;
            st         <= R_IDLE;
          end else begin
            frame_err <= 1'b1;
            st        <= R_WAIT;
          end
        end
        default: st <= R_WAIT;
      endcase
    end
endmodule

// File: rtl/menu_cmd_rx.sv
// menu_cmd_rx: parses "<digit>CR" menu commands from UART bytes into a held valid/ready selection.
module menu_cmd_rx
  import menu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  menu_cmd_rx_if.master  bus
);
  logic [7:0]       b;
  logic             bv;
  logic             fe;
  logic             issue;
  ps_state_t        ps;
  logic [SEL_W-1:0] digit;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (b),
    .byte_valid (bv),
    .frame_err  (fe)
  );
  assign bus.frame_err = fe;
  assign issue = bv && b == ASC_CR && ps == P_DIGIT;
  // A selection issued in the acceptance cycle still counts as overflow.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps            <= P_IDLE;
      digit         <= '0;
      bus.sel       <= '0;
      bus.sel_valid <= 1'b0;
      bus.menu_req  <= 1'b0;
      bus.cmd_err   <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.menu_req <= 1'b0;
      bus.cmd_err  <= 1'b0;
      bus.ovf      <= 1'b0;
      if (bus.sel_valid && bus.sel_ready) bus.sel_valid <= 1'b0;
      if (issue && bus.sel_valid) bus.ovf <= 1'b1;
      if (issue && !bus.sel_valid) begin
        bus.sel       <= digit;
        bus.sel_valid <= 1'b1;
      end
      if (bv && b != ASC_LF)
        case (ps)
          P_IDLE:
            if (is_digit(b)) begin
              digit <= b[SEL_W-1:0];
              ps    <= P_DIGIT;
            end else if (b == ASC_CR) bus.menu_req <= 1'b1;
            else ps <= P_BAD;
          P_DIGIT: begin
            digit <= '0;
            ps    <= (b == ASC_CR || b == ASC_BS || b == ASC_DEL) ? P_IDLE : P_BAD;
          end
          P_BAD:
            if (b == ASC_CR) begin
              bus.cmd_err  <= 1'b1;
              bus.menu_req <= 1'b1;
              ps           <= P_IDLE;
            end
          default: ps <= P_IDLE;
        endcase
    end
endmodule
